// File: rtl/rename_rf_ckpt.sv
// rename_rf_ckpt: architectural register file plus rename (busy/tag) table with
// commit bypass and NCKPT in-order branch checkpoints of the rename state.
module rename_rf_ckpt #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int REG_W  = 5,
    parameter int TAG_W  = 4,
    parameter int NCKPT  = 4,
    parameter int CKPT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              src1_en,
    input  logic [REG_W-1:0]  src1_idx,
    output logic              src1_vld,
    output logic              src1_rdy,
    output logic [XLEN-1:0]   src1_val,
    input  logic              src2_en,
    input  logic [REG_W-1:0]  src2_idx,
    output logic              src2_vld,
    output logic              src2_rdy,
    output logic [XLEN-1:0]   src2_val,
    input  logic              dis_en,
    input  logic [REG_W-1:0]  dis_rd,
    input  logic [TAG_W-1:0]  dis_tag,
    input  logic              cmt_en,
    input  logic [REG_W-1:0]  cmt_rd,
    input  logic [TAG_W-1:0]  cmt_tag,
    input  logic [XLEN-1:0]   cmt_val,
    input  logic              ckpt_save,
    input  logic              ckpt_restore,
    input  logic [CKPT_W-1:0] ckpt_restore_id,
    input  logic              ckpt_release,
    output logic [CKPT_W-1:0] ckpt_id,
    output logic [CKPT_W:0]   ckpt_count,
    output logic              ckpt_full
);
    logic [XLEN-1:0]   r_val [NREG];
    logic [NREG-1:0]   r_busy;
    logic [TAG_W-1:0]  r_tag [NREG];
    logic [NREG-1:0]   r_ck_busy [NCKPT];
    logic [TAG_W-1:0]  r_ck_tag [NCKPT][NREG];
    logic [CKPT_W-1:0] r_head, r_tail;
    logic [CKPT_W:0]   r_count;
    logic [XLEN:0]     r_l1, r_l2;

    logic [XLEN:0]     w_l1, w_l2;
    logic              w_cmt, w_dis, w_rel, w_rst_ok, w_save;
    logic [CKPT_W-1:0] w_off, w_head_n, w_tail_n;
    logic [CKPT_W:0]   w_count_n;
    logic [NREG-1:0]   w_busy_n;
    logic [TAG_W-1:0]  w_tag_n [NREG];
    logic [NREG-1:0]   w_ck_busy [NCKPT];

    // Returns {rdy, val} from the pre-update state, bypassing a matching commit.
    function automatic logic [XLEN:0] lookup(input logic [REG_W-1:0] idx);
        if (idx == '0) return {1'b1, {XLEN{1'b0}}};
        if (!r_busy[idx]) return {1'b1, r_val[idx]};
        if (cmt_en && cmt_tag == r_tag[idx]) return {1'b1, cmt_val};
        return {1'b0, XLEN'(r_tag[idx])};
    endfunction

    always_comb begin
        w_l1 = lookup(src1_idx);
        w_l2 = lookup(src2_idx);
    end

    assign src1_vld = src1_en;
    assign src2_vld = src2_en;
    assign {src1_rdy, src1_val} = src1_en ? w_l1 : r_l1;
    assign {src2_rdy, src2_val} = src2_en ? w_l2 : r_l2;
    assign ckpt_id    = r_tail;
    assign ckpt_count = r_count;
    assign ckpt_full  = r_count == (CKPT_W+1)'(NCKPT);

    always_comb begin
        w_cmt    = cmt_en && cmt_rd != '0;
        w_dis    = dis_en && dis_rd != '0;
        w_rel    = ckpt_release && r_count != '0;
        w_off    = ckpt_restore_id - r_head;
        w_rst_ok = ckpt_restore && ({1'b0, w_off} < r_count);
        w_save   = ckpt_save && !w_rst_ok && !ckpt_full;
        w_busy_n = r_busy;
        w_tag_n  = r_tag;
        if (w_cmt && r_tag[cmt_rd] == cmt_tag) w_busy_n[cmt_rd] = 1'b0;
        for (int k = 0; k < NCKPT; k++) begin
            w_ck_busy[k] = r_ck_busy[k];
            if (w_cmt && r_ck_tag[k][cmt_rd] == cmt_tag) w_ck_busy[k][cmt_rd] = 1'b0;
        end
        if (w_dis) begin
            w_tag_n[dis_rd]  = dis_tag;
            w_busy_n[dis_rd] = 1'b1;
        end
        w_head_n = r_head + CKPT_W'(w_rel);
        // A release that pops the restored slot itself leaves an empty, aligned queue.
        w_count_n = w_rst_ok ? (w_rel ? (w_off == '0 ? '0 : {1'b0, w_off} - 1'b1) : {1'b0, w_off})
                             : r_count - (CKPT_W+1)'(w_rel) + (CKPT_W+1)'(w_save);
        w_tail_n  = w_rst_ok ? ((w_rel && w_off == '0) ? w_head_n : ckpt_restore_id)
                             : r_tail + CKPT_W'(w_save);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val     <= '{default: '0};
            r_tag     <= '{default: '0};
            r_busy    <= '0;
            r_ck_busy <= '{default: '0};
            r_ck_tag  <= '{default: '{default: '0}};
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_l1      <= '0;
            r_l2      <= '0;
        end else begin
            if (src1_en) r_l1 <= w_l1;
            if (src2_en) r_l2 <= w_l2;
            if (flush) begin
                if (w_cmt) r_val[cmt_rd] <= cmt_val;
                r_busy  <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else if (rdy) begin
                if (w_cmt) r_val[cmt_rd] <= cmt_val;
                r_ck_busy <= w_ck_busy;
                if (w_rst_ok) begin
                    r_busy <= w_ck_busy[ckpt_restore_id];
                    r_tag  <= r_ck_tag[ckpt_restore_id];
                end else begin
                    r_busy <= w_busy_n;
                    r_tag  <= w_tag_n;
                end
                if (w_save) begin
                    r_ck_busy[r_tail] <= w_busy_n;
                    r_ck_tag[r_tail]  <= w_tag_n;
                end
                r_head  <= w_head_n;
                r_tail  <= w_tail_n;
                r_count <= w_count_n;
            end
        end
    end
endmodule

// File: tb/tb_rename_rf_ckpt.sv
// tb_rename_rf_ckpt: directed stimulus with queued expectations, checked by a
// negedge monitor whenever a lookup port or the status strobe is active.
module tb_rename_rf_ckpt;
    logic        clk = 0, rst, rdy, flush;
    logic        src1_en, src1_vld, src1_rdy, src2_en, src2_vld, src2_rdy;
    logic [4:0]  src1_idx, src2_idx, dis_rd, cmt_rd;
    logic [31:0] src1_val, src2_val, cmt_val;
    logic        dis_en, cmt_en, ckpt_save, ckpt_restore, ckpt_release, ckpt_full;
    logic [3:0]  dis_tag, cmt_tag;
    logic [1:0]  ckpt_restore_id, ckpt_id;
    logic [2:0]  ckpt_count;
    logic        chk_st;
    logic [32:0] q1[$], q2[$];
    logic [5:0]  qs[$];
    logic [32:0] e;
    int          pass_n = 0, total_n = 0;

    always #5 clk = ~clk;

    rename_rf_ckpt dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .src1_en(src1_en), .src1_idx(src1_idx), .src1_vld(src1_vld), .src1_rdy(src1_rdy), .src1_val(src1_val),
        .src2_en(src2_en), .src2_idx(src2_idx), .src2_vld(src2_vld), .src2_rdy(src2_rdy), .src2_val(src2_val),
        .dis_en(dis_en), .dis_rd(dis_rd), .dis_tag(dis_tag),
        .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
        .ckpt_release(ckpt_release), .ckpt_id(ckpt_id), .ckpt_count(ckpt_count), .ckpt_full(ckpt_full)
    );

    task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (src1_vld) begin
            if (q1.size() == 0) begin total_n++; $display("FAIL src1 unexpected output at %0t", $time); end
            else begin e = q1.pop_front(); check("src1", {src1_rdy, src1_val}, e); end
        end
        if (src2_vld) begin
            if (q2.size() == 0) begin total_n++; $display("FAIL src2 unexpected output at %0t", $time); end
            else begin e = q2.pop_front(); check("src2", {src2_rdy, src2_val}, e); end
        end
        if (chk_st) begin
            if (qs.size() == 0) begin total_n++; $display("FAIL status unexpected strobe at %0t", $time); end
            else begin e = 33'(qs.pop_front()); check("status", 33'({ckpt_full, ckpt_count, ckpt_id}), e); end
        end
    end

    task automatic idle();
        rdy = 1; flush = 0; chk_st = 0;
        src1_en = 0; src1_idx = 0; src2_en = 0; src2_idx = 0;
        dis_en = 0; dis_rd = 0; dis_tag = 0;
        cmt_en = 0; cmt_rd = 0; cmt_tag = 0; cmt_val = 0;
        ckpt_save = 0; ckpt_restore = 0; ckpt_restore_id = 0; ckpt_release = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1; idle();
    endtask

    task automatic lk(input int p, input logic [4:0] idx, input logic r, input logic [31:0] v);
        if (p == 1) begin src1_en = 1; src1_idx = idx; q1.push_back({r, v}); end
        else begin src2_en = 1; src2_idx = idx; q2.push_back({r, v}); end
    endtask

    task automatic st(input logic [2:0] c, input logic [1:0] id, input logic f);
        chk_st = 1; qs.push_back({f, c, id});
    endtask

    task automatic dis(input logic [4:0] rd, input logic [3:0] t);
        dis_en = 1; dis_rd = rd; dis_tag = t;
    endtask

    task automatic cmt(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] v);
        cmt_en = 1; cmt_rd = rd; cmt_tag = t; cmt_val = v;
    endtask

    task automatic restore(input logic [1:0] id);
        ckpt_restore = 1; ckpt_restore_id = id;
    endtask

    initial begin
        idle(); rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        lk(1, 5, 1, 0); lk(2, 0, 1, 0); st(0, 0, 0); tick();
        dis(5, 3); tick();
        lk(1, 5, 0, 3); tick();
        lk(1, 5, 1, 32'hDEAD); cmt(5, 3, 32'hDEAD); tick();
        lk(1, 5, 1, 32'hDEAD); lk(2, 5, 1, 32'hDEAD); tick();
        dis(5, 7); tick();
        lk(1, 5, 0, 7); cmt(5, 3, 32'h11); tick();
        lk(1, 5, 0, 7); tick();
        dis(6, 2); ckpt_save = 1; tick();
        st(1, 1, 0); dis(6, 4); ckpt_save = 1; tick();
        st(2, 2, 0); lk(1, 6, 0, 4); dis(7, 5); tick();
        lk(1, 7, 0, 5); restore(0); tick();
        lk(1, 6, 0, 2); lk(2, 7, 1, 0); st(0, 0, 0); tick();
        dis(8, 9); ckpt_save = 1; tick();
        st(1, 1, 0); ckpt_save = 1; tick();
        st(2, 2, 0); ckpt_save = 1; tick();
        st(3, 3, 0); ckpt_save = 1; tick();
        st(4, 0, 1); ckpt_save = 1; tick();
        st(4, 0, 1); ckpt_release = 1; tick();
        st(3, 0, 0); lk(1, 8, 1, 32'h99); cmt(8, 9, 32'h99); dis(8, 10); tick();
        lk(1, 8, 0, 10); restore(1); tick();
        lk(1, 8, 1, 32'h99); lk(2, 6, 0, 2); st(0, 1, 0); tick();
        restore(3); dis(10, 1); tick();
        lk(1, 10, 0, 1); st(0, 1, 0); tick();
        ckpt_save = 1; tick();
        st(1, 2, 0); ckpt_save = 1; tick();
        st(2, 3, 0); restore(2); ckpt_release = 1; tick();
        st(0, 2, 0); lk(1, 10, 0, 1); tick();
        flush = 1; cmt(9, 0, 32'h42); dis(11, 3); ckpt_save = 1; tick();
        lk(1, 9, 1, 32'h42); lk(2, 5, 1, 32'h11); st(0, 0, 0); dis(0, 5); tick();
        lk(1, 11, 1, 0); lk(2, 0, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            rdy = 0; dis(12, 6); ckpt_save = 1; cmt(13, 0, 32'h55);
            if (i == 0) lk(1, 12, 1, 0);
            tick();
        end
        lk(1, 12, 1, 0); lk(2, 13, 1, 0); st(0, 0, 0); tick();
        tick();
        check("drain", 33'(q1.size() + q2.size() + qs.size()), 33'd0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
